// File: rtl/arp_tx.sv
// arp_tx -- ARP frame transmitter.
//
// Builds and streams 60-byte Ethernet/ARP frames (FCS appended downstream by
// the MAC) as fifteen 32-bit words, first byte on [31:24]. Two request
// sources are supported: ARP replies (to a requester MAC/IP) and ARP who-has
// queries (broadcast, for a target IP). Each source has a pending flag plus a
// stored address, so a request that arrives while a frame is in flight is
// remembered and sent afterwards. Replies win over queries.
//
// Ports:
//   clk_user_i            single clock, rising edge
//   reset_i               synchronous, active-high reset
//   our_mac_i / our_ip_i  local addresses (Ethernet source, SHA, SPA)
//   reply_send_en_i       one-cycle reply request; samples reply_send_mac/ip
//   query_send_en_i       one-cycle query request; samples query_ip_addr_i
//   tx_arp_data_o         frame word
//   tx_arp_data_be_o      byte enable, always 2'b00 (all four bytes valid)
//   tx_arp_data_pa_o      word valid
//   tx_arp_data_sop_o     first word of frame
//   tx_arp_data_eop_o     last word of frame
//   tx_arp_rdy_i          MAC accepts the current word when pa & rdy
//   busy_o                high whenever the engine is not idle
//   frame_done_o          one-cycle pulse after the eop word is accepted
module arp_tx (
  input  logic        clk_user_i,
  input  logic        reset_i,
  input  logic [47:0] our_mac_i,
  input  logic [31:0] our_ip_i,
  input  logic        reply_send_en_i,
  input  logic [47:0] reply_send_mac_addr_i,
  input  logic [31:0] reply_send_ip_addr_i,
  input  logic        query_send_en_i,
  input  logic [31:0] query_ip_addr_i,
  output logic [31:0] tx_arp_data_o,
  output logic [1:0]  tx_arp_data_be_o,
  output logic        tx_arp_data_pa_o,
  output logic        tx_arp_data_sop_o,
  output logic        tx_arp_data_eop_o,
  input  logic        tx_arp_rdy_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_e;

  localparam logic [3:0]  LAST_WORD    = 4'd14;
  localparam logic [15:0] OPER_REQUEST = 16'h0001;
  localparam logic [15:0] OPER_REPLY   = 16'h0002;

  state_e      state_q, state_d;

  // Pending requests
  logic        rep_pend_q, rep_pend_d;
  logic [47:0] rep_mac_q,  rep_mac_d;
  logic [31:0] rep_ip_q,   rep_ip_d;
  logic        qry_pend_q, qry_pend_d;
  logic [31:0] qry_ip_q,   qry_ip_d;

  // Frame snapshot, frozen for the whole SEND phase
  logic [47:0] da_q,   da_d;
  logic [47:0] sa_q,   sa_d;
  logic [31:0] spa_q,  spa_d;
  logic [15:0] oper_q, oper_d;
  logic [47:0] tha_q,  tha_d;
  logic [31:0] tpa_q,  tpa_d;

  logic [3:0]  cnt_q,  cnt_d;

  logic [31:0] word;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    rep_pend_d = rep_pend_q;
    rep_mac_d  = rep_mac_q;
    rep_ip_d   = rep_ip_q;
    qry_pend_d = qry_pend_q;
    qry_ip_d   = qry_ip_q;
    da_d       = da_q;
    sa_d       = sa_q;
    spa_d      = spa_q;
    oper_d     = oper_q;
    tha_d      = tha_q;
    tpa_d      = tpa_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rep_pend_q || qry_pend_q) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        state_d = ST_SEND;
        cnt_d   = '0;
        sa_d    = our_mac_i;
        spa_d   = our_ip_i;
        if (rep_pend_q) begin
          da_d       = rep_mac_q;
          tha_d      = rep_mac_q;
          tpa_d      = rep_ip_q;
          oper_d     = OPER_REPLY;
          rep_pend_d = 1'b0;
        end else begin
          da_d       = '1;
          tha_d      = '0;
          tpa_d      = qry_ip_q;
          oper_d     = OPER_REQUEST;
          qry_pend_d = 1'b0;
        end
      end

      ST_SEND: begin
        if (tx_arp_rdy_i) begin
          if (cnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // New requests are applied after the LOAD clear so that a pulse landing
    // in the LOAD cycle itself stays pending for the next frame.
    if (reply_send_en_i) begin
      rep_pend_d = 1'b1;
      rep_mac_d  = reply_send_mac_addr_i;
      rep_ip_d   = reply_send_ip_addr_i;
    end
    if (query_send_en_i) begin
      qry_pend_d = 1'b1;
      qry_ip_d   = query_ip_addr_i;
    end
  end

  // Frame word selection from the snapshot
  always_comb begin
    word = '0;
    if (state_q == ST_SEND) begin
      case (cnt_q)
        4'd0:    word = da_q[47:16];
        4'd1:    word = {da_q[15:0], sa_q[47:32]};
        4'd2:    word = sa_q[31:0];
        4'd3:    word = {16'h0806, 16'h0001};
        4'd4:    word = {16'h0800, 8'h06, 8'h04};
        4'd5:    word = {oper_q, sa_q[47:32]};
        4'd6:    word = sa_q[31:0];
        4'd7:    word = spa_q;
        4'd8:    word = tha_q[47:16];
        4'd9:    word = {tha_q[15:0], tpa_q[31:16]};
        4'd10:   word = {tpa_q[15:0], 16'h0000};
        default: word = '0;
      endcase
    end
  end

  always_comb begin
    tx_arp_data_o     = word;
    tx_arp_data_be_o  = 2'b00;
    tx_arp_data_pa_o  = (state_q == ST_SEND);
    tx_arp_data_sop_o = (state_q == ST_SEND) && (cnt_q == 4'd0);
    tx_arp_data_eop_o = (state_q == ST_SEND) && (cnt_q == LAST_WORD);
    busy_o            = (state_q != ST_IDLE);
    frame_done_o      = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_user_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      rep_pend_q <= 1'b0;
      rep_mac_q  <= '0;
      rep_ip_q   <= '0;
      qry_pend_q <= 1'b0;
      qry_ip_q   <= '0;
      da_q       <= '0;
      sa_q       <= '0;
      spa_q      <= '0;
      oper_q     <= '0;
      tha_q      <= '0;
      tpa_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rep_pend_q <= rep_pend_d;
      rep_mac_q  <= rep_mac_d;
      rep_ip_q   <= rep_ip_d;
      qry_pend_q <= qry_pend_d;
      qry_ip_q   <= qry_ip_d;
      da_q       <= da_d;
      sa_q       <= sa_d;
      spa_q      <= spa_d;
      oper_q     <= oper_d;
      tha_q      <= tha_d;
      tpa_q      <= tpa_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_arp_tx.sv
// tb_arp_tx -- self-checking bench for arp_tx.
// Directed table vectors and multi-cycle sequences, then a randomized run
// checked against a byte-level frame builder and a request-queue model.
module tb_arp_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] our_mac;
  logic [31:0] our_ip;
  logic        rep_en;
  logic [47:0] rep_mac;
  logic [31:0] rep_ip;
  logic        q_en;
  logic [31:0] q_ip;
  logic        rdy;
  logic [31:0] tx_data;
  logic [1:0]  tx_be;
  logic        tx_pa, tx_sop, tx_eop, busy, fdone;

  arp_tx dut (
    .clk_user_i            (clk),
    .reset_i               (reset),
    .our_mac_i             (our_mac),
    .our_ip_i              (our_ip),
    .reply_send_en_i       (rep_en),
    .reply_send_mac_addr_i (rep_mac),
    .reply_send_ip_addr_i  (rep_ip),
    .query_send_en_i       (q_en),
    .query_ip_addr_i       (q_ip),
    .tx_arp_data_o         (tx_data),
    .tx_arp_data_be_o      (tx_be),
    .tx_arp_data_pa_o      (tx_pa),
    .tx_arp_data_sop_o     (tx_sop),
    .tx_arp_data_eop_o     (tx_eop),
    .tx_arp_rdy_i          (rdy),
    .busy_o                (busy),
    .frame_done_o          (fdone)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [47:0] OM   = 48'h000A_3501_0203;
  localparam logic [31:0] OI   = 32'hC0A8_0002;
  localparam logic [47:0] MACA = 48'h0021_CC6D_3596;
  localparam logic [31:0] IPA  = 32'hC0A8_0003;
  localparam logic [31:0] IPQ  = 32'hC0A8_0005;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte-level ARP frame: 60 bytes packed first-byte-first.
  function automatic logic [479:0] build(input bit is_q, input logic [47:0] mymac,
                                         input logic [31:0] myip, input logic [47:0] pmac,
                                         input logic [31:0] pip);
    logic [7:0]   b [60];
    logic [47:0]  da, tha;
    logic [15:0]  op;
    logic [479:0] f;
    da  = is_q ? 48'hFFFF_FFFF_FFFF : pmac;
    tha = is_q ? 48'h0 : pmac;
    op  = is_q ? 16'h0001 : 16'h0002;
    for (int i = 0; i < 60; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]      = da[47-8*i -: 8];
      b[6+i]    = mymac[47-8*i -: 8];
      b[22+i]   = mymac[47-8*i -: 8];
      b[32+i]   = tha[47-8*i -: 8];
    end
    b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
    b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
    b[20] = op[15:8]; b[21] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      b[28+i] = myip[31-8*i -: 8];
      b[38+i] = pip[31-8*i -: 8];
    end
    for (int i = 0; i < 60; i++) f[479-8*i -: 8] = b[i];
    return f;
  endfunction

  function automatic logic [31:0] wordof(input logic [479:0] f, input int i);
    return f[479-32*i -: 32];
  endfunction

  // Capture results
  logic [31:0] cap_w [15];
  logic [14:0] cap_sop_bits, cap_eop_bits;
  int unsigned cap_sop_cyc, req_cyc;
  int          cap_hold;
  bit          cap_hold_bad, cap_be_bad, cap_ok;
  logic        cap_done, cap_pa_after, cap_done2;

  // Called at a negedge; leaves the bench at a negedge.
  task automatic send_req(input bit do_rep, input bit do_q, input logic [47:0] mac,
                          input logic [31:0] rip, input logic [31:0] qip);
    rep_en = do_rep; rep_mac = mac; rep_ip = rip;
    q_en = do_q; q_ip = qip;
    @(negedge clk);
    rep_en = 1'b0; q_en = 1'b0;
    req_cyc = cyc;
  endtask

  task automatic capture(input int stall_idx, input int stall_len,
                         input int inj_idx, input logic [31:0] inj_ip);
    int idx, stalled, guard;
    idx = 0; stalled = 0; guard = 0;
    cap_sop_bits = '0; cap_eop_bits = '0; cap_hold = 0; cap_hold_bad = 0;
    cap_be_bad = 0; cap_ok = 0; cap_done = 1'b0; cap_pa_after = 1'b1; cap_done2 = 1'b1;
    for (int i = 0; i < 15; i++) cap_w[i] = '0;
    rdy = 1'b1;
    while (!(tx_pa && tx_sop) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!(tx_pa && tx_sop)) begin
      chk("sop_timeout", 0, 1);
      return;
    end
    cap_sop_cyc = cyc;
    while (idx < 15 && tx_pa && guard < 300) begin
      rep_en = 1'b0;
      if (idx == stall_idx) begin
        if (cap_hold > 0 && tx_data !== cap_w[idx]) cap_hold_bad = 1;
        cap_hold++;
      end
      cap_w[idx] = tx_data;
      cap_sop_bits[idx] = tx_sop;
      cap_eop_bits[idx] = tx_eop;
      if (tx_be !== 2'b00) cap_be_bad = 1;
      if (idx == inj_idx) begin
        rep_en = 1'b1;
        rep_ip = inj_ip;
      end
      if (idx == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = 1'b1;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    rep_en = 1'b0;
    rdy = 1'b1;
    cap_ok = (idx == 15);
    cap_done = fdone;
    cap_pa_after = tx_pa;
    @(negedge clk);
    cap_done2 = fdone;
  endtask

  task automatic verify(input string tag, input logic [479:0] f, input int exp_hold);
    chk({tag, "_complete"}, cap_ok, 1);
    for (int i = 0; i < 15; i++)
      chk($sformatf("%s_w%0d", tag, i), cap_w[i], wordof(f, i));
    chk({tag, "_sop"}, cap_sop_bits, 15'h0001);
    chk({tag, "_eop"}, cap_eop_bits, 15'h4000);
    chk({tag, "_be"}, cap_be_bad, 0);
    chk({tag, "_done_pulse"}, {cap_done, cap_pa_after, cap_done2}, 3'b100);
    if (exp_hold > 0) begin
      chk({tag, "_hold_cycles"}, cap_hold, exp_hold);
      chk({tag, "_hold_stable"}, cap_hold_bad, 0);
    end
  endtask

  typedef struct {
    bit          is_q;
    logic [47:0] pmac;
    logic [31:0] pip;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [17];

  // Random-phase model state
  bit           m_rep, m_q, in_frame, done_exp;
  logic [47:0]  m_rmac;
  logic [31:0]  m_rip, m_qip;
  logic [479:0] exp_f;
  int           ridx;

  initial begin
    #500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit          have, cur_q, stim;
    logic [31:0] cur_ip;
    logic [2:0]  acc;
    int          guard;
    int unsigned s1;

    vecs[0]  = '{0, MACA, IPA, 0,  32'h0021_CC6D};
    vecs[1]  = '{0, MACA, IPA, 1,  32'h3596_000A};
    vecs[2]  = '{0, MACA, IPA, 2,  32'h3501_0203};
    vecs[3]  = '{0, MACA, IPA, 3,  32'h0806_0001};
    vecs[4]  = '{0, MACA, IPA, 4,  32'h0800_0604};
    vecs[5]  = '{0, MACA, IPA, 5,  32'h0002_000A};
    vecs[6]  = '{0, MACA, IPA, 7,  32'hC0A8_0002};
    vecs[7]  = '{0, MACA, IPA, 9,  32'h3596_C0A8};
    vecs[8]  = '{0, MACA, IPA, 10, 32'h0003_0000};
    vecs[9]  = '{0, MACA, IPA, 14, 32'h0000_0000};
    vecs[10] = '{1, 48'h0, IPQ, 0,  32'hFFFF_FFFF};
    vecs[11] = '{1, 48'h0, IPQ, 1,  32'hFFFF_000A};
    vecs[12] = '{1, 48'h0, IPQ, 5,  32'h0001_000A};
    vecs[13] = '{1, 48'h0, IPQ, 8,  32'h0000_0000};
    vecs[14] = '{1, 48'h0, IPQ, 9,  32'h0000_C0A8};
    vecs[15] = '{1, 48'h0, IPQ, 10, 32'h0005_0000};
    vecs[16] = '{1, 48'h0, IPQ, 12, 32'h0000_0000};

    reset = 1'b1; our_mac = OM; our_ip = OI;
    rep_en = 1'b0; rep_mac = '0; rep_ip = '0; q_en = 1'b0; q_ip = '0; rdy = 1'b1;

    // Reset state, and a request pulse during reset is discarded
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_data, tx_be, tx_pa, tx_sop, tx_eop, busy, fdone}, '0);
    rep_en = 1'b1; rep_mac = MACA; rep_ip = IPA;
    @(negedge clk);
    rep_en = 1'b0;
    reset = 1'b0;
    acc = '0;
    repeat (30) begin
      @(negedge clk);
      acc |= {tx_pa, fdone, busy};
    end
    chk("reset_drops_request", acc, 3'b000);

    // Table-driven frame word checks
    have = 0; cur_q = 0; cur_ip = '0;
    for (int v = 0; v < 17; v++) begin
      if (!have || vecs[v].is_q != cur_q || vecs[v].pip != cur_ip) begin
        send_req(!vecs[v].is_q, vecs[v].is_q, vecs[v].pmac, vecs[v].pip, vecs[v].pip);
        capture(-1, 0, -1, 32'h0);
        chk("tbl_latency", cap_sop_cyc - req_cyc, 2);
        verify(vecs[v].is_q ? "tbl_qry" : "tbl_rep",
               build(vecs[v].is_q, OM, OI, vecs[v].pmac, vecs[v].pip), 0);
        have = 1; cur_q = vecs[v].is_q; cur_ip = vecs[v].pip;
      end
      chk($sformatf("tbl_v%0d_w%0d", v, vecs[v].idx), cap_w[vecs[v].idx], vecs[v].exp);
    end

    // Backpressure: rdy low for 3 cycles at w4
    send_req(1, 0, MACA, IPA, 32'h0);
    capture(4, 3, -1, 32'h0);
    verify("bp", build(0, OM, OI, MACA, IPA), 4);

    // Simultaneous reply and query
    send_req(1, 1, MACA, IPA, IPQ);
    capture(-1, 0, -1, 32'h0);
    s1 = cap_sop_cyc;
    chk("sim_latency", cap_sop_cyc - req_cyc, 2);
    verify("sim_rep", build(0, OM, OI, MACA, IPA), 0);
    capture(-1, 0, -1, 32'h0);
    chk("sim_spacing", cap_sop_cyc - s1, 18);
    verify("sim_qry", build(1, OM, OI, 48'h0, IPQ), 0);

    // Second reply pulse during SEND
    send_req(1, 0, MACA, IPA, 32'h0);
    capture(-1, 0, 5, 32'hC0A8_0009);
    verify("inj_cur", build(0, OM, OI, MACA, IPA), 0);
    capture(-1, 0, -1, 32'h0);
    verify("inj_next", build(0, OM, OI, MACA, 32'hC0A8_0009), 0);

    // Reset at w7
    send_req(1, 0, MACA, IPA, 32'h0);
    rdy = 1'b1;
    guard = 0;
    while (!(tx_pa && tx_sop) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_sop_seen", tx_pa && tx_sop, 1);
    repeat (7) @(negedge clk);
    chk("rst_w7", tx_data, wordof(build(0, OM, OI, MACA, IPA), 7));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {tx_data, tx_be, tx_pa, tx_sop, tx_eop, busy, fdone}, '0);
    reset = 1'b0;
    acc = '0;
    repeat (40) begin
      @(negedge clk);
      acc |= {tx_pa, fdone, busy};
    end
    chk("rst_no_resend", acc, 3'b000);

    // Randomized run against the request-queue model
    m_rep = 0; m_q = 0; in_frame = 0; done_exp = 0; ridx = 0;
    m_rmac = '0; m_rip = '0; m_qip = '0; exp_f = '0;
    for (int c = 0; c < 3200; c++) begin
      stim = (c < 3000);
      if (tx_pa && !in_frame) begin
        chk("rnd_frame_expected", m_rep | m_q, 1);
        if (m_rep) begin
          exp_f = build(0, our_mac, our_ip, m_rmac, m_rip);
          m_rep = 0;
        end else begin
          exp_f = build(1, our_mac, our_ip, 48'h0, m_qip);
          m_q = 0;
        end
        in_frame = 1;
        ridx = 0;
      end
      if (in_frame)
        chk("rnd_word", {busy, tx_pa, tx_sop, tx_eop, tx_be, tx_data},
            {1'b1, 1'b1, ridx == 0, ridx == 14, 2'b00, wordof(exp_f, ridx)});
      else
        chk("rnd_idle", {tx_pa, tx_sop, tx_eop, tx_data}, '0);
      chk("rnd_done", fdone, done_exp);
      done_exp = 0;
      if (rep_en) begin
        m_rep = 1; m_rmac = rep_mac; m_rip = rep_ip;
      end
      if (q_en) begin
        m_q = 1; m_qip = q_ip;
      end
      rep_en  = stim && ($urandom_range(0, 15) == 0);
      q_en    = stim && ($urandom_range(0, 15) == 0);
      rep_mac = {16'($urandom), 32'($urandom)};
      rep_ip  = $urandom;
      q_ip    = $urandom;
      if ($urandom_range(0, 63) == 0) begin
        our_mac = {16'($urandom), 32'($urandom)};
        our_ip  = $urandom;
      end
      rdy = !stim || ($urandom_range(0, 3) != 0);
      if (in_frame && rdy) begin
        if (ridx == 14) begin
          in_frame = 0;
          done_exp = 1;
        end else begin
          ridx++;
        end
      end
      @(negedge clk);
    end
    chk("rnd_drained", {m_rep, m_q, in_frame, busy}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
